// File: rtl/sfr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfr_pkg: shared 8051 SFR address map and port reset constants       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package sfr_pkg;

  localparam logic [7:0] SFR_P0     = 8'h80;
  localparam logic [7:0] SFR_P1     = 8'h90;
  localparam logic [7:0] SFR_P2     = 8'hA0;
  localparam logic [7:0] SFR_P3     = 8'hB0;
  localparam logic [7:0] SFR_SBUF   = 8'h99;
  localparam logic [7:0] SFR_B      = 8'hF0;

  localparam logic [7:0] PORT_RESET = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sync2: parameterised-width two-flop synchroniser, async reset       |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module sync2 #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   i_d,
  output logic [WIDTH-1:0]   o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= RESET_VALUE;
      r_sync <= RESET_VALUE;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sfr_simple_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfr_simple_port: 8-bit SFR-mapped output latch with pin readback    |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module sfr_simple_port
  import sfr_pkg::*;
#(
  parameter logic [7:0] SFR_ADDRESS = SFR_P1,
  parameter logic [7:0] RESET_VALUE = PORT_RESET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_byte,
  input  logic       rd_en,
  input  logic [7:0] rd_addr,
  input  logic       rd_latch,
  input  logic [7:0] pin_in,
  output logic [7:0] port_out,
  output logic [7:0] rd_byte,
  output logic       rd_hit
);

  logic [7:0] r_latch;
  logic [7:0] w_pin_sync;
  logic       w_wr_sel;
  logic       w_rd_sel;

  // Enable gates the compare so an undefined address cannot leak into state.
  assign w_wr_sel = wr_en && (wr_addr == SFR_ADDRESS);
  assign w_rd_sel = rd_en && (rd_addr == SFR_ADDRESS);

  sync2 #(
    .WIDTH       (8),
    .RESET_VALUE (RESET_VALUE)
  ) u_pin_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pin_in),
    .o_q (w_pin_sync)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_latch <= RESET_VALUE;
    end else if (w_wr_sel) begin
      r_latch <= wr_byte;
    end
  end

  // Non-selected reads drive zero so several responders can be OR-combined.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_hit  <= 1'b0;
      rd_byte <= 8'h00;
    end else begin
      rd_hit  <= w_rd_sel;
      rd_byte <= w_rd_sel ? (rd_latch ? r_latch : w_pin_sync) : 8'h00;
    end
  end

  assign port_out = r_latch;

endmodule
`default_nettype wire

// File: tb/tb_sfr_simple_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sfr_simple_port: directed bench with read-data scoreboard        |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_sfr_simple_port;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_byte;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic       rd_latch;
  logic [7:0] pin_in;
  logic [7:0] port_out;
  logic [7:0] rd_byte;
  logic       rd_hit;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  sfr_simple_port #(
    .SFR_ADDRESS (8'h90),
    .RESET_VALUE (8'hFF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_byte  (wr_byte),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_latch (rd_latch),
    .pin_in   (pin_in),
    .port_out (port_out),
    .rd_byte  (rd_byte),
    .rd_hit   (rd_hit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: every presented read response is matched against the queue.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rd_hit === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: got rd_hit=1 rd_byte=0x%02h, expected no response", rd_byte);
        end else begin
          e = exp_q.pop_front();
          if (rd_byte !== e) begin
            n_fail++;
            $display("FAIL rd_data: got 0x%02h, expected 0x%02h", rd_byte, e);
          end
        end
      end else if (!rst) begin
        check8("rd_idle_zero", rd_byte, 8'h00);
      end
    end
  end

  initial begin
    logic [7:0] sweep[15];
    rst = 1'b1; wr_en = 1'b0; wr_addr = 8'h00; wr_byte = 8'h00;
    rd_en = 1'b0; rd_addr = 8'h00; rd_latch = 1'b0; pin_in = 8'h0F;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check8("reset_port_out", port_out, 8'hFF);
    check8("reset_rd_hit", {7'd0, rd_hit}, 8'h00);
    check8("reset_rd_byte", rd_byte, 8'h00);

    // Async reset in mid-cycle after a write.
    wr_en = 1'b1; wr_addr = 8'h90; wr_byte = 8'h5A;
    tick();
    wr_en = 1'b0;
    check8("write_5a", port_out, 8'h5A);
    #2 rst = 1'b1;
    #1 check8("async_reset_port_out", port_out, 8'hFF);
    #1 rst = 1'b0;
    tick();

    // Addressed write, then a write to a neighbouring address.
    wr_en = 1'b1; wr_addr = 8'h90; wr_byte = 8'h81;
    tick();
    check8("write_81", port_out, 8'h81);
    wr_addr = 8'h91; wr_byte = 8'h3C;
    tick();
    wr_en = 1'b0;
    check8("write_other_addr", port_out, 8'h81);

    // Disabled write with undefined address/data must not disturb the latch.
    wr_addr = 8'hxx; wr_byte = 8'hxx;
    tick();
    check8("write_disabled_x", port_out, 8'h81);

    sweep = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    wr_addr = 8'h90;
    for (int i = 0; i < 15; i++) begin
      wr_en = 1'b1; wr_byte = sweep[i];
      tick();
      check8("sweep", port_out, sweep[i]);
      #3 check8("sweep_midcycle", port_out, sweep[i]);
    end
    wr_en = 1'b0;

    // Latch read while pins differ.
    wr_en = 1'b1; wr_addr = 8'h90; wr_byte = 8'hA5;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 8'h90; rd_latch = 1'b1;
    exp_q.push_back(8'hA5);
    tick();
    rd_en = 1'b0;
    tick();
    check8("rd_hit_drop", {7'd0, rd_hit}, 8'h00);
    check8("rd_byte_drop", rd_byte, 8'h00);

    // Pin read: synchroniser lags pin_in by two edges.
    pin_in = 8'hF0;
    tick();
    rd_en = 1'b1; rd_addr = 8'h90; rd_latch = 1'b0;
    exp_q.push_back(8'h0F);
    tick();
    exp_q.push_back(8'hF0);
    tick();
    rd_en = 1'b0;
    tick();

    // Same-cycle write and latch read returns the old latch value.
    wr_en = 1'b1; wr_addr = 8'h90; wr_byte = 8'h11;
    tick();
    wr_byte = 8'h77;
    rd_en = 1'b1; rd_addr = 8'h90; rd_latch = 1'b1;
    exp_q.push_back(8'h11);
    tick();
    wr_en = 1'b0;
    check8("same_cycle_port_out", port_out, 8'h77);
    exp_q.push_back(8'h77);
    tick();
    rd_addr = 8'h80;
    tick();
    rd_en = 1'b0;
    check8("rd_other_addr_hit", {7'd0, rd_hit}, 8'h00);
    repeat (2) tick();

    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
